pc_write_logic: RTL and testbench

- PC write-enable generator for the multicycle CPU datapath. Sits between the control unit (condition selects, unconditional PcWrite) and the ALU flags (GT, EQ).
- Drives the program counter register's load enable combinationally, with zero latency.
- Adds registered bookkeeping: a last-taken flag, a sticky illegal-select error, and optional taken/evaluated counters.

---
 rtl/pcw_pkg.sv | 19 +
 rtl/pcw_sat_counter.sv | 28 ++
 rtl/pc_write_logic.sv | 85 ++++++++
 tb/tb_pc_write_logic.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pcw_pkg.sv
// Shared definitions for the PC write-enable generator: condition-select
// bit positions, the packed select type and the statistics counter width default.
package pcw_pkg;

  localparam int SEL_LTE = 0;
  localparam int SEL_GT  = 1;
  localparam int SEL_EQ  = 2;
  localparam int SEL_NE  = 3;

  localparam int CNT_W_DEF = 16;

  typedef logic [3:0] sel_t;

  // More than one condition select asserted in the same cycle.
  function automatic logic sel_conflict(input sel_t s);
    return ($countones(s) > 1);
  endfunction

endpackage

// File: rtl/pcw_sat_counter.sv
// Saturating up-counter used for the optional branch statistics.
// Holds at all-ones instead of wrapping; async active-low reset to zero.
module pcw_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  // Count register: advance by one on inc, stick at the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pc_write_logic.sv
// PC load-enable generator for the multicycle datapath. pc_write and
// cond_taken are purely combinational (reset does not touch them); the
// last-taken flag, sticky select-conflict error and, when PCW_STATS_EN is
// defined, the taken/evaluated saturating counters are registered.
module pc_write_logic
  import pcw_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lte_c,
  input  logic             gt_c,
  input  logic             eq_c,
  input  logic             ne_c,
  input  logic             gt,
  input  logic             eq,
  input  logic             pc_wr,
  input  logic             err_clr,
  output logic             pc_write,
  output logic             cond_taken,
  output logic             last_taken_q,
  output logic             sel_err_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] eval_cnt
);

  sel_t sel;
  logic any_sel;
  logic multi_sel;

  // Gather the condition selects and evaluate the branch condition.
  always_comb begin
    sel          = '0;
    sel[SEL_LTE] = lte_c;
    sel[SEL_GT]  = gt_c;
    sel[SEL_EQ]  = eq_c;
    sel[SEL_NE]  = ne_c;
    cond_taken   = (sel[SEL_LTE] & ~gt) | (sel[SEL_GT] & gt) |
                   (sel[SEL_EQ] & eq)   | (sel[SEL_NE] & ~eq);
    pc_write     = pc_wr | cond_taken;
    any_sel      = |sel;
    multi_sel    = sel_conflict(sel);
  end

  // Remember the outcome of the most recent conditional evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_taken_q <= 1'b0;
    end else if (any_sel) begin
      last_taken_q <= cond_taken;
    end
  end

  // Sticky conflict flag; a new conflict beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (multi_sel) begin
      sel_err_q <= 1'b1;
    end else if (err_clr) begin
      sel_err_q <= 1'b0;
    end
  end

`ifdef PCW_STATS_EN
  pcw_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cond_taken),
    .count (taken_cnt)
  );

  pcw_sat_counter #(.CNT_W(CNT_W)) u_eval_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (any_sel),
    .count (eval_cnt)
  );
`else
  assign taken_cnt = '0;
  assign eval_cnt  = '0;
`endif

endmodule

// File: tb/tb_pc_write_logic.sv
// Directed bench for pc_write_logic: a table of single-cycle vectors with
// hand-computed combinational and post-edge expectations, followed by
// saturation and asynchronous-reset sequences. Counter expectations
// collapse to zero when PCW_STATS_EN is not defined.
module tb_pc_write_logic;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                lte_c, gt_c, eq_c, ne_c, gt, eq, pc_wr, err_clr;
  logic                pc_write, cond_taken, last_taken_q, sel_err_q;
  logic [TB_CNT_W-1:0] taken_cnt, eval_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  pc_write_logic #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lte_c        (lte_c),
    .gt_c         (gt_c),
    .eq_c         (eq_c),
    .ne_c         (ne_c),
    .gt           (gt),
    .eq           (eq),
    .pc_wr        (pc_wr),
    .err_clr      (err_clr),
    .pc_write     (pc_write),
    .cond_taken   (cond_taken),
    .last_taken_q (last_taken_q),
    .sel_err_q    (sel_err_q),
    .taken_cnt    (taken_cnt),
    .eval_cnt     (eval_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lte, gtc, eqc, nec, gt, eq, pcwr, clr;
    bit pcw, ct;
    bit last, err;
    int ev, tk;
  } vec_t;

  vec_t tbl[19];

  function automatic int cnt_exp(input int v);
`ifdef PCW_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit l, input bit g_c, input bit e_c, input bit n_c,
                       input bit g, input bit e, input bit w, input bit c);
    lte_c = l; gt_c = g_c; eq_c = e_c; ne_c = n_c;
    gt = g; eq = e; pc_wr = w; err_clr = c;
  endtask

  task automatic check_regs(input string tag, input bit last, input bit err,
                            input int ev, input int tk);
    check({tag, " last_taken_q"}, int'(last_taken_q), int'(last));
    check({tag, " sel_err_q"}, int'(sel_err_q), int'(err));
    check({tag, " eval_cnt"}, int'(eval_cnt), cnt_exp(ev));
    check({tag, " taken_cnt"}, int'(taken_cnt), cnt_exp(tk));
  endtask

  initial begin
    //           lte gtc eqc nec gt eq pcwr clr  pcw ct  last err ev  tk
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0,  0,  0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 0,   0, 0,  0,  0};
    tbl[2]  = '{0, 0, 0, 0, 1, 1, 0, 0,   0, 0,   0, 0,  0,  0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0,   1, 1,   1, 0,  1,  1};
    tbl[4]  = '{1, 0, 0, 0, 1, 0, 0, 0,   0, 0,   0, 0,  2,  1};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0,  3,  1};
    tbl[6]  = '{0, 1, 0, 0, 1, 0, 0, 0,   1, 1,   1, 0,  4,  2};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 0,   0, 0,   0, 0,  5,  2};
    tbl[8]  = '{0, 0, 1, 0, 0, 1, 0, 0,   1, 1,   1, 0,  6,  3};
    tbl[9]  = '{0, 0, 0, 1, 0, 0, 0, 0,   1, 1,   1, 0,  7,  4};
    tbl[10] = '{0, 0, 0, 1, 0, 1, 0, 0,   0, 0,   0, 0,  8,  4};
    tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 0,   1, 1,   1, 0,  9,  5};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 0, 0,   0, 0,   1, 0,  9,  5};
    tbl[13] = '{1, 1, 0, 0, 1, 0, 0, 0,   1, 1,   1, 1, 10,  6};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1,   0, 0,   1, 0, 10,  6};
    tbl[15] = '{0, 0, 1, 1, 0, 0, 0, 1,   1, 1,   1, 1, 11,  7};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 1, 11,  7};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1,   0, 0,   1, 0, 11,  7};
    tbl[18] = '{1, 0, 0, 0, 1, 0, 1, 0,   1, 0,   0, 0, 12,  7};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_regs("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].lte, tbl[i].gtc, tbl[i].eqc, tbl[i].nec,
            tbl[i].gt, tbl[i].eq, tbl[i].pcwr, tbl[i].clr);
      #1;
      check($sformatf("vec%0d pc_write", i), int'(pc_write), int'(tbl[i].pcw));
      check($sformatf("vec%0d cond_taken", i), int'(cond_taken), int'(tbl[i].ct));
      @(posedge clk);
      #1;
      check_regs($sformatf("vec%0d", i), tbl[i].last, tbl[i].err, tbl[i].ev, tbl[i].tk);
    end

    // Saturation: 20 taken EQ evaluations push both 4-bit counters to 15.
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    check_regs("sat", 1, 0, 15, 15);
    @(posedge clk);
    #1;
    check_regs("sat_hold", 1, 0, 15, 15);

    // Async reset between edges while counters are nonzero.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async_rst", 0, 0, 0, 0);
    check("async_rst pc_write", int'(pc_write), 1);
    check("async_rst cond_taken", int'(cond_taken), 1);
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    #1;
    check("async_rst pc_wr only", int'(pc_write), 1);
    check("async_rst cond_taken off", int'(cond_taken), 0);
    @(posedge clk);
    #1;
    check_regs("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_regs("post_rst", 1, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
